// File: rtl/row_feeder.sv
// -----------------------------------------------------------------------------
// row_feeder
//
// Transmit side of the cell-stream interface. Takes one row of cells as a
// parallel word over a valid/ready handshake and serialises it, MSB (cell 0)
// first, onto the single-bit din input of a row shredder. Every row is framed
// by a zero guard cell on each side so the edge cells see dead neighbours.
//
// Alongside the stream it produces cell_valid / cell_idx / row_done, delayed
// so they line up with the cycles in which the shredder's registered
// next_state output carries a real cell result.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low (0 = reset)
//   row_in     in   row word; bit WIDTH-1 is cell 0, bit 0 is cell WIDTH-1
//   row_valid  in   row_in is presented
//   row_ready  out  a row can be accepted this cycle (combinational)
//   dout       out  serial cell stream to the shredder
//   busy       out  a row is in LEAD/SHIFT/TRAIL
//   cell_valid out  shredder result for a real cell is present this cycle
//   cell_idx   out  index of that cell
//   row_done   out  pulse alongside cell_valid for the last cell of a row
// -----------------------------------------------------------------------------
module row_feeder #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] row_in,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             dout,
    output logic             busy,
    output logic             cell_valid,
    output logic [IDXW-1:0]  cell_idx,
    output logic             row_done
);

    // Counter only has to hold WIDTH-1.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             dout_reg, dout_next;
    logic             busy_reg;

    // Alignment pipeline: stage 1 plus the output registers form the 2-cycle
    // delay that matches the shredder's input register plus its output.
    logic             valid_d1_reg;
    logic [IDXW-1:0]  idx_d1_reg;
    logic             last_d1_reg;
    logic             cell_valid_reg;
    logic [IDXW-1:0]  cell_idx_reg;
    logic             row_done_reg;

    logic             xfer;
    logic [CW-1:0]    idx_cw;
    logic [IDXW-1:0]  idx_now;
    logic             shift_now;
    logic             last_now;

    // Ready is gated by reset so nothing is accepted while rst is asserted.
    assign row_ready = rst && ((state_reg == IDLE) || (state_reg == TRAIL));
    assign xfer      = row_valid && row_ready;

    // The register state names the cycle being driven on dout: while
    // state_reg is SHIFT, dout carries cell (WIDTH-1-cnt_reg).
    assign shift_now = (state_reg == SHIFT);
    assign last_now  = (cnt_reg == '0);
    assign idx_cw    = CW'(WIDTH - 1) - cnt_reg;
    assign idx_now   = IDXW'(idx_cw);

    // dout is registered, so the value for the following cycle is chosen here
    // from the shift register MSB and the register shifts as it is consumed.
    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        cnt_next   = cnt_reg;
        dout_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (xfer) begin
                    sr_next    = row_in;
                    state_next = LEAD;
                end
            end
            LEAD: begin
                dout_next  = sr_reg[WIDTH-1];
                sr_next    = {sr_reg[WIDTH-2:0], 1'b0};
                cnt_next   = CW'(WIDTH - 1);
                state_next = SHIFT;
            end
            SHIFT: begin
                if (last_now) begin
                    // Next cycle is the right guard.
                    state_next = TRAIL;
                end else begin
                    dout_next = sr_reg[WIDTH-1];
                    sr_next   = {sr_reg[WIDTH-2:0], 1'b0};
                    cnt_next  = cnt_reg - 1'b1;
                end
            end
            TRAIL: begin
                if (xfer) begin
                    sr_next    = row_in;
                    state_next = LEAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    // Independent of the FSM so results of a row keep draining after the
    // FSM has moved on to the next row or back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_d1_reg   <= 1'b0;
            idx_d1_reg     <= '0;
            last_d1_reg    <= 1'b0;
            cell_valid_reg <= 1'b0;
            cell_idx_reg   <= '0;
            row_done_reg   <= 1'b0;
        end else begin
            valid_d1_reg   <= shift_now;
            idx_d1_reg     <= shift_now ? idx_now : '0;
            last_d1_reg    <= shift_now && last_now;
            cell_valid_reg <= valid_d1_reg;
            cell_idx_reg   <= idx_d1_reg;
            row_done_reg   <= last_d1_reg;
        end
    end

    assign dout       = dout_reg;
    assign busy       = busy_reg;
    assign cell_valid = cell_valid_reg;
    assign cell_idx   = cell_idx_reg;
    assign row_done   = row_done_reg;

endmodule

// File: tb/tb_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_row_feeder
//
// Directed bench for row_feeder. A WIDTH=16 instance covers reset, a single
// row, back-to-back rows, input blocking while busy and an asynchronous reset
// mid-row; a WIDTH=2 instance covers the minimal width. Cycle c0 is the cycle
// in which a row is accepted; outputs are sampled 1 time unit after each
// rising edge, which is also where inputs are driven.
// -----------------------------------------------------------------------------
module tb_row_feeder;

    logic        clk;
    logic        rst;

    logic [15:0] row_in;
    logic        row_valid;
    logic        row_ready;
    logic        dout;
    logic        busy;
    logic        cell_valid;
    logic [3:0]  cell_idx;
    logic        row_done;

    logic [1:0]  row2_in;
    logic        row2_valid;
    logic        row2_ready;
    logic        dout2;
    logic        busy2;
    logic        cell_valid2;
    logic [0:0]  cell_idx2;
    logic        row_done2;

    int checks;
    int errors;

    row_feeder #(.WIDTH(16), .IDXW(4)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .dout       (dout),
        .busy       (busy),
        .cell_valid (cell_valid),
        .cell_idx   (cell_idx),
        .row_done   (row_done)
    );

    row_feeder #(.WIDTH(2), .IDXW(1)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row2_in),
        .row_valid  (row2_valid),
        .row_ready  (row2_ready),
        .dout       (dout2),
        .busy       (busy2),
        .cell_valid (cell_valid2),
        .cell_idx   (cell_idx2),
        .row_done   (row_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s c%0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    // dout for c1..c18 of row 16'hA5C3, c1 in the MSB
    logic [17:0] exp_single;
    logic [15:0] latched;
    logic        exp_d;
    logic        exp_cv;

    initial begin
        checks     = 0;
        errors     = 0;
        exp_single = 18'b010100101110000110;
        rst        = 1'b0;
        row_in     = 16'hFFFF;
        row_valid  = 1'b1;
        row2_in    = 2'b00;
        row2_valid = 1'b0;

        // ---------------- reset values ----------------
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ready", c, row_ready, 1'b0);
            chk("rst_dout", c, dout, 1'b0);
            chk("rst_cv", c, cell_valid, 1'b0);
            chk("rst_idx", c, cell_idx, 4'd0);
            chk("rst_busy", c, busy, 1'b0);
            chk("rst_done", c, row_done, 1'b0);
        end
        row_valid = 1'b0;
        rst       = 1'b1;
        tick();
        chk("post_rst_ready", 0, row_ready, 1'b1);
        chk("post_rst_busy", 0, busy, 1'b0);
        chk("post_rst_dout", 0, dout, 1'b0);

        // ---------------- single row A5C3 ----------------
        row_in    = 16'hA5C3;
        row_valid = 1'b1;
        chk("single_ready_c0", 0, row_ready, 1'b1);
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 1) row_valid = 1'b0;
            exp_d  = (c <= 18) ? exp_single[18-c] : 1'b0;
            exp_cv = (c >= 4) && (c <= 19);
            chk("single_dout", c, dout, exp_d);
            chk("single_cv", c, cell_valid, exp_cv);
            if (exp_cv) chk("single_idx", c, cell_idx, c - 4);
            chk("single_done", c, row_done, c == 19);
            chk("single_ready", c, row_ready, c >= 18);
            chk("single_busy", c, busy, c <= 18);
        end

        // ---------------- back-to-back FFFF then 0001 ----------------
        row_in    = 16'hFFFF;
        row_valid = 1'b1;
        chk("b2b_ready_c0", 0, row_ready, 1'b1);
        for (int c = 1; c <= 39; c++) begin
            tick();
            if (c == 1)  row_in = 16'h0001;
            if (c == 19) row_valid = 1'b0;
            if (c >= 2 && c <= 17)       exp_d = 1'b1;
            else if (c == 35)            exp_d = 1'b1;
            else                         exp_d = 1'b0;
            exp_cv = ((c >= 4) && (c <= 19)) || ((c >= 22) && (c <= 37));
            chk("b2b_dout", c, dout, exp_d);
            chk("b2b_cv", c, cell_valid, exp_cv);
            if (c >= 4 && c <= 19)  chk("b2b_idx", c, cell_idx, c - 4);
            if (c >= 22 && c <= 37) chk("b2b_idx", c, cell_idx, c - 22);
            chk("b2b_done", c, row_done, (c == 19) || (c == 37));
            if (c == 18 || c == 19) chk("b2b_ready", c, row_ready, c == 18);
        end

        // ---------------- input blocking while busy ----------------
        latched   = 16'h3C96;
        row_in    = latched;
        row_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c <= 17) row_in = (c % 2 == 1) ? 16'hFFFF : 16'h0000;
            else         row_valid = 1'b0;
            exp_d = (c >= 2 && c <= 17) ? latched[17-c] : 1'b0;
            chk("blk_dout", c, dout, exp_d);
            if (c <= 17) chk("blk_ready", c, row_ready, 1'b0);
            if (c >= 19) chk("blk_busy", c, busy, 1'b0);
        end

        // ---------------- async reset mid-row ----------------
        row_in    = 16'hFFFF;
        row_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) row_valid = 1'b0;
        end
        chk("ar_pre_dout", 8, dout, 1'b1);
        chk("ar_pre_cv", 8, cell_valid, 1'b1);
        chk("ar_pre_busy", 8, busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_dout", 8, dout, 1'b0);
        chk("ar_cv", 8, cell_valid, 1'b0);
        chk("ar_busy", 8, busy, 1'b0);
        chk("ar_ready", 8, row_ready, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("ar_quiet_cv", c, cell_valid, 1'b0);
            chk("ar_quiet_done", c, row_done, 1'b0);
            chk("ar_quiet_dout", c, dout, 1'b0);
        end
        row_in    = 16'h8001;
        row_valid = 1'b1;
        chk("ar_fresh_ready", 0, row_ready, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) row_valid = 1'b0;
            chk("ar_fresh_dout", c, dout, (c == 2) || (c == 17));
            chk("ar_fresh_cv", c, cell_valid, (c >= 4) && (c <= 19));
            chk("ar_fresh_done", c, row_done, c == 19);
        end

        // ---------------- minimal width WIDTH=2 ----------------
        row2_in    = 2'b10;
        row2_valid = 1'b1;
        chk("w2_ready_c0", 0, row2_ready, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) row2_valid = 1'b0;
            chk("w2_dout", c, dout2, c == 2);
            chk("w2_cv", c, cell_valid2, (c == 4) || (c == 5));
            if (c == 4 || c == 5) chk("w2_idx", c, cell_idx2, c - 4);
            chk("w2_done", c, row_done2, c == 5);
            chk("w2_busy", c, busy2, c <= 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
